// File: rtl/vdp_write_fifo.sv
// CPU-side VRAM write port: a 4-byte I/O window holding a VRAM address pointer,
// plus a write FIFO that the VDP drains through a request/grant handshake.
module vdp_write_fifo #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          DEPTH     = 8,
    parameter int          VRAM_AW   = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        address,
    input  logic [7:0]         dataIn,
    input  logic               write,
    input  logic               read,
    output logic               chipSelect,
    output logic [7:0]         dataOut,
    output logic               vramReq,
    input  logic               vramGrant,
    output logic               vramWrite,
    output logic [VRAM_AW-1:0] vramAddress,
    output logic [7:0]         vramData
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = VRAM_AW + 8;

    localparam logic [1:0] R_PTR_LO = 2'd0;
    localparam logic [1:0] R_PTR_HI = 2'd1;
    localparam logic [1:0] R_DATA   = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

    state_t             state_q, state_d;
    logic [VRAM_AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               vram_req_q, vram_req_d;
    logic               vram_write_q, vram_write_d;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         vram_data_q, vram_data_d;
    logic [EW-1:0]      mem [DEPTH];

    logic          sel, full, empty, push, push_ok, drop, pop, status_rd;
    logic [EW-1:0] head;
    logic [15:0]   ptr16;
    logic [7:0]    status;

    assign sel       = (address[15:2] == BASE_ADDR[15:2]);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = sel && write && (address[1:0] == R_DATA);
    assign push_ok   = push && !full;
    assign drop      = push && full;
    assign pop       = (state_q == S_WRITE);
    assign status_rd = sel && read && (address[1:0] == R_STATUS);
    assign head      = mem[rd_ptr_q];
    assign ptr16     = 16'(ptr_q);
    assign status    = {overflow_q, full, empty, 1'b0, 4'(count_q)};

    assign chipSelect  = sel;
    assign vramReq     = vram_req_q;
    assign vramWrite   = vram_write_q;
    assign vramAddress = vram_addr_q;
    assign vramData    = vram_data_q;

    always_comb begin
        dataOut = 8'h00;
        if (sel) begin
            case (address[1:0])
                R_PTR_LO: dataOut = ptr16[7:0];
                R_PTR_HI: dataOut = ptr16[15:8];
                R_DATA:   dataOut = 8'h00;
                default:  dataOut = status;
            endcase
        end
    end

    // Pointer advances only on an accepted push; a dropped byte leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (sel && write) begin
            case (address[1:0])
                R_PTR_LO: ptr_d = {ptr_q[VRAM_AW-1:8], dataIn};
                R_PTR_HI: ptr_d = VRAM_AW'({dataIn, ptr_q[7:0]});
                R_DATA:   if (!full) ptr_d = ptr_q + VRAM_AW'(1);
                default:  ptr_d = ptr_q;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        if (status_rd) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_REQ;
            S_REQ:   if (vramGrant) state_d = S_WRITE;
            S_WRITE: state_d = (count_d != '0) ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        vram_req_d   = (state_d == S_REQ);
        vram_write_d = (state_d == S_WRITE);
        vram_addr_d  = vram_addr_q;
        vram_data_d  = vram_data_q;
        if (state_d == S_WRITE) begin
            vram_addr_d = head[EW-1:8];
            vram_data_d = head[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            vram_req_q   <= 1'b0;
            vram_write_q <= 1'b0;
            vram_addr_q  <= '0;
            vram_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            vram_req_q   <= vram_req_d;
            vram_write_q <= vram_write_d;
            vram_addr_q  <= vram_addr_d;
            vram_data_q  <= vram_data_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {ptr_q, dataIn};
    end

endmodule

// File: tb/tb_vdp_write_fifo.sv
// Directed bench for vdp_write_fifo: register access, drain timing, overflow,
// pointer wrap, drop-on-pop and reset in mid-operation.
module tb_vdp_write_fifo;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  dataIn;
    logic        write, read;
    logic        chipSelect;
    logic [7:0]  dataOut;
    logic        vramReq, vramGrant, vramWrite;
    logic [13:0] vramAddress;
    logic [7:0]  vramData;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    logic [13:0] mon_addr[$];
    logic [7:0]  mon_data[$];
    int          mon_cyc[$];

    vdp_write_fifo #(.BASE_ADDR(16'hFF00), .DEPTH(8), .VRAM_AW(14)) dut (
        .clk(clk), .reset(reset), .address(address), .dataIn(dataIn),
        .write(write), .read(read), .chipSelect(chipSelect), .dataOut(dataOut),
        .vramReq(vramReq), .vramGrant(vramGrant), .vramWrite(vramWrite),
        .vramAddress(vramAddress), .vramData(vramData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (vramWrite === 1'b1) begin
            mon_addr.push_back(vramAddress);
            mon_data.push_back(vramData);
            mon_cyc.push_back(cyc_n);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        address = {BASE[15:2], r};
        dataIn  = d;
        write   = 1'b1;
        cyc();
        write   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [7:0] v);
        address = {BASE[15:2], r};
        read    = 1'b1;
        #1;
        v = dataOut;
        cyc();
        read    = 1'b0;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (mon_addr.size() < n && k < budget) begin
            cyc();
            k++;
        end
        n_chk++;
        if (mon_addr.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pulses, exp %0d", nm, mon_addr.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b0; vramGrant = 1'b0; address = 16'h0000; dataIn = 8'h00;
        write = 1'b0; read = 1'b0;
        repeat (2) cyc();
        n_chk++;
        if ({vramReq, vramWrite} !== 2'b00) begin
            n_fail++; $display("FAIL rst_strobes: got %b exp 00", {vramReq, vramWrite});
        end
        n_chk++;
        if ({vramAddress, vramData} !== 22'h0) begin
            n_fail++; $display("FAIL rst_vram_bus: got %h/%h exp 0/0", vramAddress, vramData);
        end
        reset = 1'b1;
        cyc();
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL rst_status: got %h exp 20", v); end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL rst_ptr_lo: got %h exp 00", v); end
        address = 16'h1234;
        #1;
        n_chk++;
        if ({chipSelect, dataOut} !== 9'h000) begin
            n_fail++; $display("FAIL unsel_decode: got cs=%b do=%h exp 0/00", chipSelect, dataOut);
        end
        rd(2'd2, v);
        n_chk++;
        if ({chipSelect, v} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL data_reg_read: got cs=%b do=%h exp 1/00", chipSelect, v);
        end
        wr(2'd3, 8'hFF);
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL status_write_noop: got %h exp 20", v); end
    endtask

    task automatic test_single_write();
        logic [7:0] v;
        int t0;
        vramGrant = 1'b1;
        wr(2'd0, 8'h34);
        wr(2'd1, 8'h12);
        clear_mon();
        t0 = cyc_n;
        wr(2'd2, 8'hAA);
        wait_pulses(1, 10, "t1");
        if (mon_addr.size() >= 1) begin
            n_chk++;
            if (mon_cyc[0] - t0 !== 3) begin
                n_fail++; $display("FAIL t1_latency: got %0d exp 3", mon_cyc[0] - t0);
            end
            n_chk++;
            if ({mon_addr[0], mon_data[0]} !== {14'h1234, 8'hAA}) begin
                n_fail++; $display("FAIL t1_entry: got %h/%h exp 1234/aa", mon_addr[0], mon_data[0]);
            end
        end
        cyc();
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL t1_status: got %h exp 20", v); end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h35) begin n_fail++; $display("FAIL t1_ptr_inc: got %h exp 35", v); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        vramGrant = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h00);
        for (int i = 0; i < 9; i++) wr(2'd2, 8'h10 + 8'(i));
        n_chk++;
        if ({vramReq, vramWrite} !== 2'b10) begin
            n_fail++; $display("FAIL t2_req_hold: got %b exp 10", {vramReq, vramWrite});
        end
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'hC8) begin n_fail++; $display("FAIL t2_status_ovf: got %h exp c8", v); end
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h48) begin n_fail++; $display("FAIL t2_status_clr: got %h exp 48", v); end
    endtask

    task automatic test_drain();
        logic [7:0] v;
        clear_mon();
        vramGrant = 1'b1;
        wait_pulses(8, 40, "t3");
        repeat (6) cyc();
        n_chk++;
        if (mon_addr.size() !== 8) begin
            n_fail++; $display("FAIL t3_pulse_count: got %0d exp 8", mon_addr.size());
        end
        for (int i = 0; i < 8 && i < mon_addr.size(); i++) begin
            n_chk++;
            if ({mon_addr[i], mon_data[i]} !== {14'(i), 8'h10 + 8'(i)}) begin
                n_fail++;
                $display("FAIL t3_entry%0d: got %h/%h exp %h/%h", i, mon_addr[i], mon_data[i],
                         14'(i), 8'h10 + 8'(i));
            end
            if (i > 0) begin
                n_chk++;
                if (mon_cyc[i] - mon_cyc[i-1] !== 2) begin
                    n_fail++;
                    $display("FAIL t3_spacing%0d: got %0d exp 2", i, mon_cyc[i] - mon_cyc[i-1]);
                end
            end
        end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h08) begin n_fail++; $display("FAIL t3_ptr_lo: got %h exp 08", v); end
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL t3_status: got %h exp 20", v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hFF);
        rd(2'd1, v);
        n_chk++;
        if (v !== 8'h3F) begin n_fail++; $display("FAIL t4_ptr_hi_mask: got %h exp 3f", v); end
        clear_mon();
        wr(2'd2, 8'h55);
        wr(2'd2, 8'h66);
        wait_pulses(2, 20, "t4");
        if (mon_addr.size() >= 2) begin
            n_chk++;
            if ({mon_addr[0], mon_data[0]} !== {14'h3FFF, 8'h55}) begin
                n_fail++; $display("FAIL t4_first: got %h/%h exp 3fff/55", mon_addr[0], mon_data[0]);
            end
            n_chk++;
            if ({mon_addr[1], mon_data[1]} !== {14'h0000, 8'h66}) begin
                n_fail++; $display("FAIL t4_wrap: got %h/%h exp 0000/66", mon_addr[1], mon_data[1]);
            end
        end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL t4_ptr_after: got %h exp 01", v); end
    endtask

    task automatic test_drop_on_pop();
        logic [7:0] v;
        vramGrant = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        for (int i = 0; i < 8; i++) wr(2'd2, 8'h20 + 8'(i));
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h48) begin n_fail++; $display("FAIL t5_full: got %h exp 48", v); end
        clear_mon();
        vramGrant = 1'b1;
        cyc();
        n_chk++;
        if ({vramWrite, vramAddress} !== {1'b1, 14'h0100}) begin
            n_fail++; $display("FAIL t5_in_write: got %b/%h exp 1/0100", vramWrite, vramAddress);
        end
        vramGrant = 1'b0;
        wr(2'd2, 8'h99);
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h87) begin n_fail++; $display("FAIL t5_drop_status: got %h exp 87", v); end
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h07) begin n_fail++; $display("FAIL t5_status_clr: got %h exp 07", v); end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h08) begin n_fail++; $display("FAIL t5_ptr_kept: got %h exp 08", v); end
        vramGrant = 1'b1;
        wait_pulses(8, 40, "t5");
        repeat (6) cyc();
        n_chk++;
        if (mon_addr.size() !== 8) begin
            n_fail++; $display("FAIL t5_pulse_count: got %0d exp 8", mon_addr.size());
        end
        for (int i = 0; i < 8 && i < mon_addr.size(); i++) begin
            n_chk++;
            if ({mon_addr[i], mon_data[i]} !== {14'h0100 + 14'(i), 8'h20 + 8'(i)}) begin
                n_fail++;
                $display("FAIL t5_entry%0d: got %h/%h exp %h/%h", i, mon_addr[i], mon_data[i],
                         14'h0100 + 14'(i), 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] v;
        vramGrant = 1'b0;
        for (int i = 0; i < 3; i++) wr(2'd2, 8'h40 + 8'(i));
        repeat (2) cyc();
        n_chk++;
        if (vramReq !== 1'b1) begin n_fail++; $display("FAIL t6_req_before: got %b exp 1", vramReq); end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({vramReq, vramWrite} !== 2'b00) begin
            n_fail++; $display("FAIL t6_async_clear: got %b exp 00", {vramReq, vramWrite});
        end
        repeat (2) cyc();
        reset = 1'b1;
        clear_mon();
        vramGrant = 1'b1;
        repeat (10) cyc();
        n_chk++;
        if (mon_addr.size() !== 0) begin
            n_fail++; $display("FAIL t6_no_write: got %0d pulses exp 0", mon_addr.size());
        end
        rd(2'd3, v);
        n_chk++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL t6_status: got %h exp 20", v); end
        rd(2'd0, v);
        n_chk++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL t6_ptr: got %h exp 00", v); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_overflow();
        test_drain();
        test_wrap();
        test_drop_on_pop();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
